// File: rtl/byte_un_striping_n.sv
// Merges NUM_LANES striped lane words back into one stream in strict round-robin lane order.
// Each lane has a small skew FIFO so lanes may arrive up to FIFO_DEPTH words apart.
module byte_un_striping_n #(
  parameter int unsigned NUM_LANES  = 2,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                           clk_nf,
  input  logic                           reset,
  input  logic [$clog2(NUM_LANES):0]     active_lanes,
  input  logic [NUM_LANES-1:0]           valid_in,
  input  logic [NUM_LANES*WIDTH-1:0]     lanes_in,
  output logic                           valid_out,
  output logic [WIDTH-1:0]               data_out,
  output logic [NUM_LANES-1:0]           overflow
);

  localparam int unsigned CW = $clog2(NUM_LANES) + 1;
  localparam int unsigned PW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0]     r_mem [NUM_LANES][FIFO_DEPTH];
  logic [AW:0]          r_wp  [NUM_LANES];
  logic [AW:0]          r_rp  [NUM_LANES];
  logic [PW-1:0]        r_ptr;
  logic [CW-1:0]        r_eff;
  logic                 r_valid;
  logic [WIDTH-1:0]     r_data;
  logic [NUM_LANES-1:0] r_ovf;

  logic [NUM_LANES-1:0] w_empty;
  logic [NUM_LANES-1:0] w_full;
  logic [NUM_LANES-1:0] w_lane_act;
  logic [NUM_LANES-1:0] w_rd_lane;
  logic [NUM_LANES-1:0] w_wr_en;
  logic [NUM_LANES-1:0] w_drop;
  logic                 w_rd_en;
  logic                 w_ptr_last;
  logic                 w_all_empty;
  logic [CW-1:0]        w_act_eff;
  logic [AW:0]          w_rp_sel;
  logic [WIDTH-1:0]     w_head;

  always_comb begin
    w_act_eff = active_lanes;
    if (active_lanes == '0 || int'(active_lanes) > int'(NUM_LANES)) begin
      w_act_eff = CW'(NUM_LANES);
    end
  end

  always_comb begin
    w_empty    = '0;
    w_full     = '0;
    w_lane_act = '0;
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      w_empty[i]    = (r_wp[i] == r_rp[i]);
      // Same index, opposite lap bit: writer is a full lap ahead.
      w_full[i]     = (r_wp[i][AW] != r_rp[i][AW]) && (r_wp[i][AW-1:0] == r_rp[i][AW-1:0]);
      w_lane_act[i] = (i < int'(r_eff));
    end
  end

  always_comb begin
    w_rd_en     = !w_empty[r_ptr];
    w_ptr_last  = (CW'(r_ptr) == (r_eff - CW'(1)));
    w_all_empty = &w_empty;
    w_rp_sel    = r_rp[r_ptr];
    w_head      = r_mem[r_ptr][w_rp_sel[AW-1:0]];
  end

  // A full FIFO still accepts a write when its head is popped on the same edge.
  always_comb begin
    w_rd_lane = '0;
    w_wr_en   = '0;
    w_drop    = '0;
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      w_rd_lane[i] = w_rd_en && (int'(r_ptr) == i);
      w_wr_en[i]   = valid_in[i] && w_lane_act[i] && (!w_full[i] || w_rd_lane[i]);
      w_drop[i]    = valid_in[i] && w_lane_act[i] && w_full[i] && !w_rd_lane[i];
    end
  end

  always_ff @(posedge clk_nf) begin
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      if (reset && w_wr_en[i]) begin
        r_mem[i][r_wp[i][AW-1:0]] <= lanes_in[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk_nf) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_LANES); i++) begin
        r_wp[i] <= '0;
        r_rp[i] <= '0;
      end
      r_ptr   <= '0;
      r_eff   <= w_act_eff;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ovf   <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_LANES); i++) begin
        if (w_wr_en[i]) begin
          r_wp[i] <= r_wp[i] + 1'b1;
        end
        if (w_rd_lane[i]) begin
          r_rp[i] <= r_rp[i] + 1'b1;
        end
        if (w_drop[i]) begin
          r_ovf[i] <= 1'b1;
        end
      end
      r_valid <= w_rd_en;
      if (w_rd_en) begin
        r_data <= w_head;
        r_ptr  <= w_ptr_last ? '0 : r_ptr + 1'b1;
      end
      // Lane count only changes at a clean frame boundary.
      if (w_all_empty && r_ptr == '0) begin
        r_eff <= w_act_eff;
      end
    end
  end

  assign valid_out = r_valid;
  assign data_out  = r_data;
  assign overflow  = r_ovf;

endmodule
